contador_lotes_multi: RTL
=========================

// Module: contador_lotes_multi
// PURPOSE
//   Multi-channel group ("lote") counter: the parametrised successor of the single-channel
//   dozen counter. Each channel counts rising edges of its own increment/decrement strobes
//   into units. Every GROUP_SIZE units becomes one group. Per channel: selectable wrap or
//   saturate at MAX_GROUPS, and a synchronous clear. A registered total across channels
//   feeds the display/packing controller.
// PARAMETERS
//   N_CH        4    number of independent channels
//   GROUP_SIZE  12   units per group (>=2)
//   MAX_GROUPS  10   highest legal group count; groups range 0..MAX_GROUPS
//   GW          7    group counter width per channel; must hold MAX_GROUPS
//   UW          4    unit counter width; = $clog2(GROUP_SIZE)
//   SATURATE    0    0 = wrap to 0 after MAX_GROUPS; 1 = hold at the full value
//   TW          10   total_groups width; must hold N_CH*MAX_GROUPS
// PORTS
//   clk           in   1        rising-edge clock
//   reset_n       in   1        asynchronous, active-low reset
//   incrementar   in   N_CH     level inputs, already synchronised; rising edge = +1 unit
//   decrementar   in   N_CH     level inputs, already synchronised; rising edge = -1 unit
//   limpar        in   N_CH     synchronous per-channel clear, level-sensitive
//   unit_count    out  N_CH*UW  packed units in current group, channel 0 at LSBs
//   group_count   out  N_CH*GW  packed completed groups, channel 0 at LSBs
//   group_done    out  N_CH     1-cycle pulse when a group completes
//   wrap_pulse    out  N_CH     1-cycle pulse when a channel wraps MAX_GROUPS -> 0 (SATURATE=0)
//   full          out  N_CH     level: group==MAX_GROUPS and unit==GROUP_SIZE-1
//   total_groups  out  TW       registered sum of all group_count fields
// BEHAVIOUR
//   - Reset (reset_n=0, asynchronous): all counters, edge-history flops, pulses, full and
//     total_groups go to 0.
//   - Edge detection per channel: inc_p = incrementar & ~inc_prev; dec_p likewise.
//     History flops update every cycle, including cycles where limpar is active.
//   - Latency: counters update on the same clock edge that first samples the input high.
//     A held-high level counts once. total_groups lags group_count by exactly 1 cycle.
//   - Per-channel priority: limpar > (inc_p & dec_p: no change) > inc_p > dec_p.
//   - limpar: unit=0 and group=0; no pulses.
//   - Increment:
//       unit < GROUP_SIZE-1: unit+1.
//       Otherwise (group completes): unit=0, group_done=1, then:
//         group < MAX_GROUPS: group+1.
//         group == MAX_GROUPS, SATURATE=0: group=0, wrap_pulse=1.
//         group == MAX_GROUPS, SATURATE=1: increment ignored; counters hold at full,
//           no pulses.
//   - Decrement:
//       unit > 0: unit-1.
//       unit==0, group>0: unit=GROUP_SIZE-1, group-1.
//       unit==0, group==0: ignored (no underflow, no pulse).
//   - Pulse outputs are registered, high for exactly one cycle, and coincide with the
//     counter update.
//   - Channels are fully independent. Simultaneous events on several channels are all
//     applied in the same cycle.
//   - Reset mid-operation clears immediately. An input held high through reset release
//     counts once: history is 0 after reset, so the first sampled high level is an edge.
// STRUCTURE
//   - Shared package contador_pkg: SATURATE/WRAP mode constants and width helper functions
//     (clog2 wrapper), shared with the v2 counter family.
//   - Sub-module contador_lotes_canal: one channel (edge detect, unit/group counters,
//     pulses, full). Instantiated N_CH times in a generate loop.
//   - Top level: packing of per-channel fields and the registered adder tree for
//     total_groups.
// TESTING
//   1. Reset, then 12 edges on ch0 (defaults) -> unit 0, group 1, group_done pulses once
//      on the 12th; other channels stay 0.
//   2. Hold incrementar[1] high for 20 cycles -> unit_count[1]=1 only; the level does not
//      re-count.
//   3. SATURATE=0: from group=10, unit=11, one edge -> group 0, unit 0, group_done and
//      wrap_pulse both high for 1 cycle.
//      SATURATE=1: same stimulus -> hold at 10/11, full=1, no pulses.
//   4. ch2 at unit 0, group 3, one decrementar edge -> unit 11, group 2.
//      At 0/0, a decrement edge leaves 0/0.
//   5. Same-cycle inc and dec edges on ch3 -> no change. Same cycle, limpar[0] with an inc
//      edge on ch0 -> ch0 cleared; inc edges on ch1..ch3 still counted.
//   6. Load groups 1/2/3/4 on channels 0..3 -> total_groups=10 one cycle after the last
//      update. Assert reset_n mid-count -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared definitions for the v2 counter family: overflow mode constants and width helpers.
package contador_pkg;

    typedef enum logic {
        MODE_WRAP     = 1'b0,
        MODE_SATURATE = 1'b1
    } modo_t;

    function automatic int unsigned clog2_w(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/contador_lotes_canal.sv
// One counting channel: strobe edge detection, unit/group counters, completion pulses and full flag.
module contador_lotes_canal
    import contador_pkg::*;
#(
    parameter int unsigned GROUP_SIZE = 12,
    parameter int unsigned MAX_GROUPS = 10,
    parameter int unsigned GW         = 7,
    parameter int unsigned UW         = clog2_w(GROUP_SIZE),
    parameter int unsigned SATURATE   = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          incrementar,
    input  logic          decrementar,
    input  logic          limpar,
    output logic [UW-1:0] unit_count,
    output logic [GW-1:0] group_count,
    output logic          group_done,
    output logic          wrap_pulse,
    output logic          full
);

    localparam logic [UW-1:0] UNIT_LAST  = UW'(GROUP_SIZE - 1);
    localparam logic [GW-1:0] GROUP_LAST = GW'(MAX_GROUPS);
    localparam bit            SAT        = (SATURATE == 32'(MODE_SATURATE));

    logic [UW-1:0] r_unit;
    logic [GW-1:0] r_group;
    logic          r_inc_prev;
    logic          r_dec_prev;
    logic          r_done;
    logic          r_wrap;

    logic          w_inc_p;
    logic          w_dec_p;
    logic [UW-1:0] w_unit_nx;
    logic [GW-1:0] w_group_nx;
    logic          w_done_nx;
    logic          w_wrap_nx;

    assign w_inc_p = incrementar & ~r_inc_prev;
    assign w_dec_p = decrementar & ~r_dec_prev;

    always_comb begin
        w_unit_nx  = r_unit;
        w_group_nx = r_group;
        w_done_nx  = 1'b0;
        w_wrap_nx  = 1'b0;
        if (limpar) begin
            w_unit_nx  = '0;
            w_group_nx = '0;
        end else if (w_inc_p && !w_dec_p) begin
            if (r_unit != UNIT_LAST) begin
                w_unit_nx = r_unit + UW'(1);
            end else if (r_group != GROUP_LAST) begin
                w_unit_nx  = '0;
                w_group_nx = r_group + GW'(1);
                w_done_nx  = 1'b1;
            end else if (!SAT) begin
                w_unit_nx  = '0;
                w_group_nx = '0;
                w_done_nx  = 1'b1;
                w_wrap_nx  = 1'b1;
            end
        end else if (w_dec_p && !w_inc_p) begin
            if (r_unit != '0) begin
                w_unit_nx = r_unit - UW'(1);
            end else if (r_group != '0) begin
                w_unit_nx  = UNIT_LAST;
                w_group_nx = r_group - GW'(1);
            end
        end
    end

    // History flops track the raw levels every cycle, independent of limpar.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_unit     <= '0;
            r_group    <= '0;
            r_inc_prev <= 1'b0;
            r_dec_prev <= 1'b0;
            r_done     <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_unit     <= w_unit_nx;
            r_group    <= w_group_nx;
            r_inc_prev <= incrementar;
            r_dec_prev <= decrementar;
            r_done     <= w_done_nx;
            r_wrap     <= w_wrap_nx;
        end
    end

    assign unit_count  = r_unit;
    assign group_count = r_group;
    assign group_done  = r_done;
    assign wrap_pulse  = r_wrap;
    assign full        = (r_unit == UNIT_LAST) && (r_group == GROUP_LAST);

endmodule

// File: rtl/contador_lotes_multi.sv
// Multi-channel group counter: per-channel counters packed onto flat buses plus a registered group total.
module contador_lotes_multi
    import contador_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned GROUP_SIZE = 12,
    parameter int unsigned MAX_GROUPS = 10,
    parameter int unsigned GW         = 7,
    parameter int unsigned UW         = 4,
    parameter int unsigned SATURATE   = 0,
    parameter int unsigned TW         = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_CH-1:0]      incrementar,
    input  logic [N_CH-1:0]      decrementar,
    input  logic [N_CH-1:0]      limpar,
    output logic [N_CH*UW-1:0]   unit_count,
    output logic [N_CH*GW-1:0]   group_count,
    output logic [N_CH-1:0]      group_done,
    output logic [N_CH-1:0]      wrap_pulse,
    output logic [N_CH-1:0]      full,
    output logic [TW-1:0]        total_groups
);

    logic [TW-1:0] r_total;
    logic [TW-1:0] w_sum;

    for (genvar g = 0; g < N_CH; g++) begin : gen_canal
        contador_lotes_canal #(
            .GROUP_SIZE (GROUP_SIZE),
            .MAX_GROUPS (MAX_GROUPS),
            .GW         (GW),
            .UW         (UW),
            .SATURATE   (SATURATE)
        ) u_canal (
            .clk         (clk),
            .reset_n     (reset_n),
            .incrementar (incrementar[g]),
            .decrementar (decrementar[g]),
            .limpar      (limpar[g]),
            .unit_count  (unit_count[g*UW +: UW]),
            .group_count (group_count[g*GW +: GW]),
            .group_done  (group_done[g]),
            .wrap_pulse  (wrap_pulse[g]),
            .full        (full[g])
        );
    end

    always_comb begin
        w_sum = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            w_sum = w_sum + TW'(group_count[c*GW +: GW]);
        end
    end

    // Sum of the registered group fields, so the total trails group_count by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_total <= '0;
        end else begin
            r_total <= w_sum;
        end
    end

    assign total_groups = r_total;

endmodule
